// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake and reg_file write port.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for MUL* ops.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  wr_en,
  output logic [4:0]            wr_addr
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wr_en_q, wr_en_d;
  logic [N-1:0]   result_q, result_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [2:0]     op_q, op_d;
  logic           a_neg_q, a_neg_d;
  logic           b_neg_q, b_neg_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Issue-time decode of the raw request
  logic         in_div, in_a_sgn, in_b_sgn, in_a_neg, in_b_neg;
  logic         in_div0, in_ovf, in_special;
  logic [N-1:0] in_a_mag, in_b_mag, special_res;

  assign in_div     = op[2];
  assign in_a_sgn   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign in_b_sgn   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign in_a_neg   = in_a_sgn && rs1_data[N-1];
  assign in_b_neg   = in_b_sgn && rs2_data[N-1];
  assign in_a_mag   = in_a_neg ? (~rs1_data + 1'b1) : rs1_data;
  assign in_b_mag   = in_b_neg ? (~rs2_data + 1'b1) : rs2_data;
  assign in_div0    = in_div && (rs2_data == '0);
  assign in_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_data == {1'b1, {(N-1){1'b0}}}) && (rs2_data == '1);
  assign in_special = in_div0 || in_ovf;
  // op[1] distinguishes REM/REMU from DIV/DIVU
  assign special_res = in_div0 ? (op[1] ? rs1_data : '1)
                               : (op[1] ? '0 : rs1_data);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*N-1:0] fm_a, fm_b, fm_prod;
  logic [N-1:0]   fast_res;
  assign fm_a     = {{N{in_a_neg}}, rs1_data};
  assign fm_b     = {{N{in_b_neg}}, rs2_data};
  assign fm_prod  = fm_a * fm_b;
  assign fast_res = (op == OP_MUL) ? fm_prod[N-1:0] : fm_prod[2*N-1:N];
`endif

  // Multiply step: hi accumulates, lo holds the remaining multiplier bits
  logic [N:0]   mul_sum;
  logic [N-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi  = mul_sum[N:1];
  assign mul_lo  = {mul_sum[0], lo_q[N-1:1]};

  // Restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in
  logic [N:0]   div_shift, div_diff;
  logic         div_ge;
  logic [N-1:0] div_hi, div_lo;
  assign div_shift = {hi_q, lo_q[N-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[N];
  assign div_hi    = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
  assign div_lo    = {lo_q[N-2:0], div_ge};

  logic [N-1:0]   step_hi, step_lo, quo_s, rem_s, final_res;
  logic [2*N-1:0] prod_s;
  assign step_hi = op_q[2] ? div_hi : mul_hi;
  assign step_lo = op_q[2] ? div_lo : mul_lo;
  assign prod_s  = (a_neg_q ^ b_neg_q) ? (~{step_hi, step_lo} + 1'b1) : {step_hi, step_lo};
  assign quo_s   = (a_neg_q ^ b_neg_q) ? (~step_lo + 1'b1) : step_lo;
  assign rem_s   = a_neg_q ? (~step_hi + 1'b1) : step_hi;

  always_comb begin
    case (op_q)
      OP_MUL:        final_res = prod_s[N-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_s[2*N-1:N];
      3'd4, 3'd5:    final_res = quo_s;
      default:       final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    result_d  = '0;
    wr_addr_d = wr_addr_q;
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          wr_addr_d = rd_in;
          a_neg_d   = in_a_neg;
          b_neg_d   = in_b_neg;
          cnt_d     = '0;
          hi_d      = '0;
          lo_d      = in_div ? in_a_mag : in_b_mag;
          opnd_d    = in_div ? in_b_mag : in_a_mag;
          if (in_special) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            wr_en_d  = (rd_in != 5'd0);
            result_d = special_res;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            wr_en_d  = (rd_in != 5'd0);
            result_d = fast_res;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          wr_en_d  = (wr_addr_q != 5'd0);
          result_d = final_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      result_q  <= '0;
      wr_addr_q <= '0;
      op_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      result_q  <= result_d;
      wr_addr_q <= wr_addr_d;
      op_q      <= op_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign result  = result_q;
  assign wr_addr = wr_addr_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes reference results, a negedge monitor pops on done.
module tb_muldiv_unit;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [N-1:0]  rs1 = '0, rs2 = '0;
  logic [4:0]    rd_in = '0;
  logic          busy, done, wr_en;
  logic [N-1:0]  result;
  logic [4:0]    wr_addr;

  muldiv_unit #(.DATA_WIDTH(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1), .rs2_data(rs2), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    logic signed [31:0] a32, b32, q;
    logic ovf;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    a32 = a;
    b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = a32 / b32; return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = a32 % b32; return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return N + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every negedge, done pops the scoreboard; otherwise outputs must be quiet
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("wr_en", 32'(wr_en), 32'(e.addr != 0));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (!reset) begin
      chk("idle_result", result, 32'h0);
      chk("idle_wr_en", 32'(wr_en), 32'h0);
    end
  end

  // Called at a negedge with the unit idle; returns the sampling edge index and latency
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit track, output int t, output int lat);
    exp_t e;
    op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
    t = cyc + 1;
    lat = latency(o, a, b);
    if (track) begin
      e.res = ref_res(o, a, b); e.addr = rd; e.cyc = t + lat - 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input int t, input int lat);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    chk("busy_fall_cycle", cyc, t + lat);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int t, lat;
    issue(o, a, b, rd, 1'b1, t, lat);
    finish_op(t, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, lat;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run(3'd5, 32'd100, 32'd7, 5'd7);
    run(3'd5, 32'd5, 32'd0, 5'd8);
    run(3'd7, 32'd5, 32'd0, 5'd9);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run(3'd4, 32'h8000_0000, 32'd1, 5'd0);

    // Abort mid-divide with reset; no write may appear
    issue(3'd4, 32'd1000, 32'd3, 5'd9, 1'b0, t, lat);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    run(3'd5, 32'd1000, 32'd3, 5'd12);

    // start re-asserted mid-CALC is ignored
    issue(3'd6, 32'hDEAD_BEEF, 32'd13, 5'd13, 1'b1, t, lat);
    repeat (4) @(negedge clk);
    op = 3'd0; rs1 = 32'd3; rs2 = 32'd3; rd_in = 5'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(t, lat);

    // start held through the DONE cycle of a special-case op is ignored
    issue(3'd5, 32'd9, 32'd0, 5'd15, 1'b1, t, lat);
    op = 3'd5; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(t, lat);

    for (int i = 0; i < 40; i++)
      run(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
